// File: rtl/filt_pkg.sv
// Shared definitions for the filter scheduler: filter select codes and the
// sequencer state encoding.
package filt_pkg;

  localparam logic [1:0] FILT_SEL_LPF = 2'b00;
  localparam logic [1:0] FILT_SEL_HPF = 2'b01;
  localparam logic [1:0] FILT_SEL_BPF = 2'b10;
  // Unused code; requests carrying it are dropped.
  localparam logic [1:0] FILT_SEL_INV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } filt_state_e;

endpackage

// File: rtl/filt_sample_fifo.sv
// Sample buffer between the XADC capture path and the sequencer.
// Synchronous first-word fall-through FIFO: dout_o shows the head entry
// whenever empty_o is low.
//   clk, rst      : clock, synchronous active-high reset
//   push_i/din_i  : write request and data (ignored when full)
//   pop_i         : read request (ignored when empty)
//   full_o/empty_o: occupancy flags
//   dout_o        : head entry
module filt_sample_fifo #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] dout_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers are AW bits wide, so they wrap modulo the depth on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/filt_sched.sv
// Sample scheduler/sequencer for the FIR filter core. Buffers incoming
// samples, runs one filter pass per sample (start pulse, wait for done),
// and presents each result on a valid/ready output. Filter selection
// changes are applied only while idle so a pass never sees a switch.
//   s_valid/s_ready/s_data  : sample input handshake
//   sel_req/sel_update      : requested filter and its latch strobe
//   filt_start/filt_select/filt_input : drive to the filter core
//   filt_result/filt_done   : filter core response (done is a level)
//   m_valid/m_ready/m_data  : result output handshake
//   busy                    : sequencer active or samples queued
//   timeout_err/clr_err     : sticky timeout flag and its clear
module filt_sched
  import filt_pkg::*;
#(
  parameter int XADC_DATA_SIZE  = 16,
  parameter int FIFO_ADDR_SIZE  = 3,
  parameter int START_PULSE_LEN = 2,
  parameter int TIMEOUT         = 1024,
  parameter int TIMEOUT_SIZE    = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [XADC_DATA_SIZE-1:0] s_data,
  input  logic [1:0]                sel_req,
  input  logic                      sel_update,
  output logic                      filt_start,
  output logic [1:0]                filt_select,
  output logic [XADC_DATA_SIZE-1:0] filt_input,
  input  logic [XADC_DATA_SIZE-1:0] filt_result,
  input  logic                      filt_done,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [XADC_DATA_SIZE-1:0] m_data,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      clr_err
);

  localparam logic [TIMEOUT_SIZE-1:0] START_LAST = TIMEOUT_SIZE'(START_PULSE_LEN - 1);
  localparam logic [TIMEOUT_SIZE-1:0] TMO_LAST   = TIMEOUT_SIZE'(TIMEOUT - 1);

  filt_state_e               state_q, state_d;
  logic [TIMEOUT_SIZE-1:0]   cnt_q, cnt_d;
  logic                      sel_pend_q, sel_pend_d;
  logic [1:0]                sel_val_q, sel_val_d;
  logic [1:0]                filt_select_q, filt_select_d;
  logic                      filt_start_q, filt_start_d;
  logic [XADC_DATA_SIZE-1:0] filt_input_q, filt_input_d;
  logic                      done_prev_q;
  logic                      done_seen_q, done_seen_d;
  logic                      m_valid_q, m_valid_d;
  logic [XADC_DATA_SIZE-1:0] m_data_q, m_data_d;
  logic                      timeout_err_q, timeout_err_d;

  logic                      fifo_pop, fifo_full, fifo_empty;
  logic [XADC_DATA_SIZE-1:0] fifo_dout;
  logic                      done_rise, sel_strobe, tmo_fire;

  filt_sample_fifo #(
    .DW(XADC_DATA_SIZE),
    .AW(FIFO_ADDR_SIZE)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s_valid),
    .din_i   (s_data),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (fifo_dout)
  );

  assign done_rise  = filt_done && !done_prev_q;
  assign sel_strobe = sel_update && (sel_req != FILT_SEL_INV);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_pend_d    = sel_pend_q;
    sel_val_d     = sel_val_q;
    filt_select_d = filt_select_q;
    filt_start_d  = filt_start_q;
    filt_input_d  = filt_input_q;
    done_seen_d   = done_seen_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    fifo_pop      = 1'b0;
    tmo_fire      = 1'b0;

    // A newer strobe always overwrites the pending request.
    if (sel_strobe) begin
      sel_pend_d = 1'b1;
      sel_val_d  = sel_req;
    end

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Applying a pending select costs one idle cycle and always runs
        // before the next start, so every pass uses the newest selection.
        if (sel_pend_q) begin
          filt_select_d = sel_val_q;
          if (!sel_strobe) sel_pend_d = 1'b0;
        end else if (!fifo_empty && !m_valid_q) begin
          fifo_pop     = 1'b1;
          filt_input_d = fifo_dout;
          filt_start_d = 1'b1;
          done_seen_d  = 1'b0;
          cnt_d        = '0;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        // A fast filter may finish while start is still asserted; keep
        // the edge so WAIT completes immediately.
        if (done_rise) done_seen_d = 1'b1;
        if (cnt_q == START_LAST) begin
          filt_start_d = 1'b0;
          cnt_d        = '0;
          state_d      = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (done_rise || done_seen_q) begin
          m_data_d    = filt_result;
          m_valid_d   = 1'b1;
          done_seen_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_fire = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Set beats clear when both land in the same cycle.
    if (tmo_fire)     timeout_err_d = 1'b1;
    else if (clr_err) timeout_err_d = 1'b0;
    else              timeout_err_d = timeout_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sel_pend_q    <= 1'b0;
      sel_val_q     <= FILT_SEL_LPF;
      filt_select_q <= FILT_SEL_LPF;
      filt_start_q  <= 1'b0;
      filt_input_q  <= '0;
      done_prev_q   <= 1'b0;
      done_seen_q   <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_pend_q    <= sel_pend_d;
      sel_val_q     <= sel_val_d;
      filt_select_q <= filt_select_d;
      filt_start_q  <= filt_start_d;
      filt_input_q  <= filt_input_d;
      done_prev_q   <= filt_done;
      done_seen_q   <= done_seen_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign s_ready     = !fifo_full;
  assign filt_start  = filt_start_q;
  assign filt_select = filt_select_q;
  assign filt_input  = filt_input_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_filt_sched.sv
// Bench for filt_sched: directed scenarios plus a randomized phase, scored
// against a queue-based reference (samples in, results out in order,
// result = filter function of sample and the select in force at start).
module tb_filt_sched;

  logic        clk, rst;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic [1:0]  sel_req;
  logic        sel_update;
  logic        filt_start;
  logic [1:0]  filt_select;
  logic [15:0] filt_input, filt_result;
  logic        filt_done;
  logic        m_valid, m_ready;
  logic [15:0] m_data;
  logic        busy, timeout_err, clr_err;

  filt_sched dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .sel_req(sel_req), .sel_update(sel_update),
    .filt_start(filt_start), .filt_select(filt_select), .filt_input(filt_input),
    .filt_result(filt_result), .filt_done(filt_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  int          cyc = 0;
  logic [15:0] in_q[$];        // accepted samples not yet started
  logic [15:0] cur_res;        // expected result of the pass in flight
  bit          cur_v = 0;
  logic [1:0]  exp_sel = 2'b00;
  int          n_push = 0, n_out = 0;
  int          wait_entry = -1;
  bit          prev_start = 0;
  // filter core model
  bit          fm_busy = 0, fm_hang = 0, fm_rand = 0;
  int          fm_cnt = 0, fm_lat = 10;

  function automatic logic [15:0] fref(logic [15:0] x, logic [1:0] s);
    logic [15:0] t;
    t = 16'(x * 16'd3);
    return t ^ {s, 14'h0155};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Advance one edge, then let the filter model react to registered outputs.
  task automatic tick();
    logic [15:0] e;
    @(posedge clk); #1;
    cyc++;
    if (filt_start === 1'b1 && !prev_start) begin
      chk("start_has_item", 32'(in_q.size() > 0), 32'd1);
      if (in_q.size() > 0) begin
        e = in_q.pop_front();
        chk("start_input", filt_input, e);
        chk("start_sel", filt_select, exp_sel);
        cur_res = fref(e, exp_sel);
        cur_v   = 1;
      end
      fm_busy = 1; fm_cnt = 0; filt_done = 1'b0;
      if (fm_rand) fm_lat = $urandom_range(1, 15);
    end else if (fm_busy) begin
      fm_cnt++;
      if (!fm_hang && fm_cnt >= fm_lat) begin
        filt_done   = 1'b1;
        filt_result = fref(filt_input, filt_select);
        fm_busy     = 0;
      end
    end
    if (filt_start !== 1'b1 && prev_start) wait_entry = cyc;
    prev_start = (filt_start === 1'b1);
  endtask

  task automatic step(bit sv, logic [15:0] sd, bit mr);
    s_valid = sv; s_data = sd; m_ready = mr;
    if (sv && s_ready === 1'b1) begin in_q.push_back(sd); n_push++; end
    if (m_valid === 1'b1 && mr) begin
      chk("out_has_item", 32'(cur_v), 32'd1);
      chk("out_data", m_data, cur_res);
      cur_v = 0; n_out++;
    end
    tick();
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 400 && (in_q.size() > 0 || cur_v || busy === 1'b1); i++)
      step(0, 16'h0, 1'b1);
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    int t0, acc, tcount;
    rst = 1; s_valid = 0; s_data = 0; sel_req = 0; sel_update = 0;
    filt_result = 0; filt_done = 0; m_ready = 0; clr_err = 0;

    // reset
    step(0, 0, 0); step(0, 0, 0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_filt_start", filt_start, 1'b0);
    chk("rst_filt_select", filt_select, 2'b00);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_m_data", m_data, 16'h0);
    rst = 0;
    step(0, 0, 0);

    // single sample, filter latency 10
    fm_lat = 10;
    step(1, 16'h1234, 0);
    step(0, 0, 0);
    t0 = cyc;
    chk("single_start_e1", filt_start, 1'b1);
    chk("single_input", filt_input, 16'h1234);
    step(0, 0, 0);
    chk("single_start_e2", filt_start, 1'b1);
    step(0, 0, 0);
    chk("single_start_drop", filt_start, 1'b0);
    while (cyc < t0 + 10) step(0, 0, 0);
    chk("single_done_raised", filt_done, 1'b1);
    chk("single_mvalid_early", m_valid, 1'b0);
    step(0, 0, 0);
    chk("single_mvalid", m_valid, 1'b1);
    chk("single_mdata", m_data, fref(16'h1234, 2'b00));
    step(0, 0, 1);
    chk("single_mvalid_clr", m_valid, 1'b0);

    // randomized traffic with random filter latency and output stalls
    fm_rand = 1;
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0));
    drain("rand_drain_idle");
    chk("rand_count", n_out, n_push);
    fm_rand = 0;

    // backpressure: one in the filter plus a full FIFO
    fm_lat = 5; acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (s_ready === 1'b1) acc++;
      step(1, 16'($urandom), 0);
    end
    chk("bp_accepted", acc, 9);
    chk("bp_s_ready", s_ready, 1'b0);
    chk("bp_busy", busy, 1'b1);
    drain("bp_drain_idle");
    chk("bp_count", n_out, n_push);

    // select change while waiting on the filter
    fm_lat = 12; wait_entry = -1;
    step(1, 16'hA5A5, 0);
    for (int i = 0; i < 20 && wait_entry < 0; i++) step(0, 0, 0);
    chk("sel_in_wait", 32'(wait_entry >= 0), 32'd1);
    sel_req = 2'b10; sel_update = 1;
    step(0, 0, 0);
    sel_update = 0;
    for (int i = 0; i < 30 && m_valid !== 1'b1; i++) begin
      chk("sel_hold_wait", filt_select, 2'b00);
      step(0, 0, 0);
    end
    chk("sel_result_valid", m_valid, 1'b1);
    step(0, 0, 1);
    exp_sel = 2'b10;
    chk("sel_applied", filt_select, 2'b10);
    sel_req = 2'b11; sel_update = 1;
    step(0, 0, 0);
    sel_update = 0;
    step(1, 16'h0F0F, 1);
    drain("sel_drain_idle");
    chk("sel_ignore_11", filt_select, 2'b10);

    // timeout: filter never completes
    fm_hang = 1; wait_entry = -1;
    step(1, 16'h1111, 1);
    step(1, 16'h2222, 1);
    for (int i = 0; i < 20 && wait_entry < 0; i++) step(0, 0, 1);
    chk("tmo_wait_entry", 32'(wait_entry >= 0), 32'd1);
    while (cyc < wait_entry + 1023) step(0, 0, 1);
    chk("tmo_not_yet", timeout_err, 1'b0);
    step(0, 0, 1);
    chk("tmo_fired", timeout_err, 1'b1);
    chk("tmo_no_mvalid", m_valid, 1'b0);
    cur_v = 0; fm_hang = 0; fm_busy = 0;
    step(0, 0, 1);
    chk("tmo_next_start", filt_start, 1'b1);
    drain("tmo_drain_idle");
    chk("tmo_sticky", timeout_err, 1'b1);
    clr_err = 1;
    step(0, 0, 1);
    clr_err = 0;
    chk("tmo_cleared", timeout_err, 1'b0);

    // reset while waiting with samples queued
    fm_lat = 30; wait_entry = -1;
    for (int i = 0; i < 4; i++) step(1, 16'($urandom), 0);
    for (int i = 0; i < 20 && wait_entry < 0; i++) step(0, 0, 0);
    chk("rstw_in_wait", 32'(wait_entry >= 0), 32'd1);
    chk("rstw_queued", busy, 1'b1);
    rst = 1;
    step(0, 0, 0);
    in_q.delete(); cur_v = 0; exp_sel = 2'b00; fm_busy = 0; filt_done = 0;
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_m_valid", m_valid, 1'b0);
    chk("rstw_start", filt_start, 1'b0);
    chk("rstw_s_ready", s_ready, 1'b1);
    chk("rstw_select", filt_select, 2'b00);
    chk("rstw_input", filt_input, 16'h0);
    rst = 0;
    tcount = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1);
      if (filt_start === 1'b1) tcount++;
    end
    chk("rstw_no_spurious", tcount, 0);
    chk("rstw_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
